// File: rtl/hazard_sched.sv
// Decode-stage hazard scheduler: tracks in-flight register writers, stalls on
// RAW/WAW hazards or a full window, flushes fetch on taken branches, and drains on request.
module hazard_sched #(
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned CNT_W        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_valid,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic             use_rs2_d,
    input  logic [4:0]       rd_d,
    input  logic             regwrite_d,
    input  logic             pcsrc_d,
    input  logic             wb_valid,
    input  logic             wb_we,
    input  logic [4:0]       wb_rd,
    input  logic             drain_req,
    output logic             stall_f,
    output logic             stall_d,
    output logic             bubble_e,
    output logic             flush_f,
    output logic             drain_done,
    output logic [CNT_W-1:0] inflight,
    output logic             err
);

    typedef enum logic {
        RUN,
        DRAIN
    } state_t;

    state_t           state_q;
    logic [31:0]      pend_q;
    logic [31:0]      pend_d;
    logic [31:0]      clr;
    logic [31:0]      eff;
    logic [31:0]      set_vec;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             err_q;
    logic             err_d;
    logic             done_q;
    logic             hazard;
    logic             full;
    logic             stall;
    logic             issue;

    always_comb begin
        // Write-through register file: a writer retiring this cycle no longer blocks readers.
        clr = '0;
        if (wb_we) begin
            clr[wb_rd] = 1'b1;
        end
        eff = pend_q & ~clr;

        hazard = dec_valid & (eff[rs1_d] | (use_rs2_d & eff[rs2_d]) | (regwrite_d & eff[rd_d]));
        full   = (cnt_q == CNT_W'(MAX_INFLIGHT)) & ~wb_valid;
        // Gated by reset so every combinational output is low while reset is held.
        stall  = reset & (hazard | full | ((state_q == DRAIN) & dec_valid));
        issue  = reset & dec_valid & ~stall;

        set_vec = '0;
        if (issue && regwrite_d && (rd_d != 5'd0)) begin
            set_vec[rd_d] = 1'b1;
        end
        pend_d = eff | set_vec;

        cnt_d = cnt_q;
        err_d = err_q;
        if (issue && !wb_valid) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!issue && wb_valid && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (wb_valid && (cnt_q == '0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            pend_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            done_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (drain_req) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((cnt_q == '0) && (pend_q == '0)) begin
                        done_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign stall_f    = stall;
    assign stall_d    = stall;
    assign bubble_e   = stall;
    assign flush_f    = issue & pcsrc_d;
    assign drain_done = done_q;
    assign inflight   = cnt_q;
    assign err        = err_q;

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched: expectations are queued per step and
// popped/compared at the mid-cycle sampling point.
module tb_hazard_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dec_valid, use_rs2_d, regwrite_d, pcsrc_d;
    logic [4:0] rs1_d, rs2_d, rd_d, wb_rd;
    logic       wb_valid, wb_we, drain_req;
    logic       stall_f, stall_d, bubble_e, flush_f, drain_done, err;
    logic [3:0] inflight;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    hazard_sched #(.MAX_INFLIGHT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(rst_n), .dec_valid(dec_valid), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .use_rs2_d(use_rs2_d), .rd_d(rd_d), .regwrite_d(regwrite_d), .pcsrc_d(pcsrc_d),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .drain_req(drain_req),
        .stall_f(stall_f), .stall_d(stall_d), .bubble_e(bubble_e), .flush_f(flush_f),
        .drain_done(drain_done), .inflight(inflight), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input string tag);
        case (tag)
            "stall":  return {29'd0, stall_f, stall_d, bubble_e};
            "flush":  return {31'd0, flush_f};
            "infl":   return {28'd0, inflight};
            "done":   return {31'd0, drain_done};
            "err":    return {31'd0, err};
            default:  return 32'hdead_beef;
        endcase
    endfunction

    task automatic ex(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk();
        exp_t        e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.tag);
            checks++;
            assert (o === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h at %0t", e.tag, o, e.val, $time);
            end
        end
    endtask

    task automatic idle();
        dec_valid = 0; rs1_d = 0; rs2_d = 0; use_rs2_d = 0; rd_d = 0;
        regwrite_d = 0; pcsrc_d = 0; wb_valid = 0; wb_we = 0; wb_rd = 0; drain_req = 0;
    endtask

    task automatic dec(input logic [4:0] rs1, input logic [4:0] rs2, input logic use2,
                       input logic [4:0] rd, input logic rw, input logic pc);
        dec_valid = 1; rs1_d = rs1; rs2_d = rs2; use_rs2_d = use2;
        rd_d = rd; regwrite_d = rw; pcsrc_d = pc;
    endtask

    task automatic wb(input logic we, input logic [4:0] rd);
        wb_valid = 1; wb_we = we; wb_rd = rd;
    endtask

    task automatic cyc();
        #3;
        chk();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        rst_n = 0;
        idle();
        dec(5'd0, 5'd0, 0, 5'd0, 0, 1);
        ex("stall", 0); ex("flush", 0); ex("infl", 0); ex("done", 0); ex("err", 0);
        #3 chk();
        @(posedge clk); #1;
        rst_n = 1;
        idle();

        // Build up state, enter drain, then reset mid-operation
        dec(5'd0, 5'd0, 0, 5'd5, 1, 0); ex("stall", 0); ex("infl", 0); cyc();
        dec(5'd1, 5'd0, 0, 5'd6, 1, 0); ex("stall", 0); ex("infl", 1); cyc();
        dec(5'd0, 5'd0, 0, 5'd7, 1, 0); drain_req = 1; ex("stall", 0); ex("infl", 2); cyc();
        dec(5'd0, 5'd0, 0, 5'd0, 0, 0); ex("stall", 7); ex("infl", 3);
        #3 chk();
        rst_n = 0;
        dec(5'd5, 5'd0, 0, 5'd0, 0, 1);
        ex("stall", 0); ex("flush", 0); ex("infl", 0); ex("done", 0); ex("err", 0);
        #1 chk();
        @(posedge clk); #1;
        rst_n = 1;
        idle();
        dec(5'd5, 5'd6, 1, 5'd0, 0, 0); ex("stall", 0); ex("infl", 0); cyc();
        wb(0, 5'd0); ex("infl", 1); cyc();

        // Load-use: consumer stalls until the producer's WB cycle
        dec(5'd0, 5'd0, 0, 5'd5, 1, 0); ex("stall", 0); ex("infl", 0); cyc();
        dec(5'd5, 5'd0, 0, 5'd8, 1, 0); ex("stall", 7); ex("infl", 1); cyc();
        dec(5'd5, 5'd0, 0, 5'd8, 1, 0); ex("stall", 7); ex("infl", 1); cyc();
        dec(5'd5, 5'd0, 0, 5'd8, 1, 0); wb(1, 5'd5); ex("stall", 0); ex("infl", 1); cyc();
        wb(1, 5'd8); ex("infl", 1); cyc();

        // x0 never pending; same-cycle clear and set of x3
        dec(5'd0, 5'd0, 0, 5'd0, 1, 0); ex("stall", 0); ex("infl", 0); cyc();
        dec(5'd0, 5'd0, 1, 5'd0, 1, 0); ex("stall", 0); ex("infl", 1); cyc();
        dec(5'd0, 5'd0, 0, 5'd3, 1, 0); ex("stall", 0); ex("infl", 2); cyc();
        dec(5'd0, 5'd0, 0, 5'd3, 1, 0); wb(1, 5'd3); ex("stall", 0); ex("infl", 3); cyc();
        dec(5'd3, 5'd0, 0, 5'd0, 0, 0); ex("stall", 7); ex("infl", 3); cyc();
        wb(0, 5'd0); ex("infl", 3); cyc();
        wb(1, 5'd3); ex("infl", 2); cyc();
        wb(0, 5'd0); ex("infl", 1); cyc();

        // Taken branch stalled on rs1: flush only in the issue cycle
        dec(5'd0, 5'd0, 0, 5'd9, 1, 0); ex("stall", 0); ex("flush", 0); ex("infl", 0); cyc();
        dec(5'd9, 5'd0, 0, 5'd0, 0, 1); ex("stall", 7); ex("flush", 0); cyc();
        dec(5'd9, 5'd0, 0, 5'd0, 0, 1); wb(1, 5'd9); ex("stall", 0); ex("flush", 1); ex("infl", 1); cyc();
        wb(0, 5'd0); ex("flush", 0); ex("infl", 1); cyc();

        // Full window: fifth issue waits, then issues alongside a retire
        for (int i = 0; i < 4; i++) begin
            dec(5'd0, 5'd0, 0, 5'd0, 0, 0); ex("stall", 0); ex("infl", i); cyc();
        end
        dec(5'd0, 5'd0, 0, 5'd0, 0, 0); ex("stall", 7); ex("infl", 4); cyc();
        dec(5'd0, 5'd0, 0, 5'd0, 0, 0); wb(0, 5'd0); ex("stall", 0); ex("infl", 4); cyc();
        wb(0, 5'd0); ex("infl", 4); cyc();
        wb(0, 5'd0); ex("infl", 3); cyc();

        // Drain with two in flight
        drain_req = 1; ex("infl", 2); ex("done", 0); cyc();
        dec(5'd0, 5'd0, 0, 5'd0, 0, 0); wb(0, 5'd0); ex("stall", 7); ex("infl", 2); ex("done", 0); cyc();
        dec(5'd0, 5'd0, 0, 5'd0, 0, 0); wb(0, 5'd0); ex("stall", 7); ex("infl", 1); ex("done", 0); cyc();
        ex("infl", 0); ex("done", 0); cyc();
        ex("done", 1); cyc();
        wb(0, 5'd0); ex("done", 0); ex("err", 0); ex("infl", 0); cyc();
        ex("err", 1); ex("infl", 0); cyc();

        // Drain when already empty
        drain_req = 1; ex("done", 0); cyc();
        ex("done", 0); cyc();
        ex("done", 1); cyc();
        ex("done", 0); ex("err", 1); cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
